// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer and SCK generator; strobes mark the clk edge on which SCK toggles.
module spi_sck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             toggle_en,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol_idle,
  input  logic             cpol_frame,
  output logic             half_stb,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             sck
);

  logic [DIV_W-1:0] cnt_r;
  logic             toggle_s;

  assign half_stb  = run && (cnt_r == div);
  assign toggle_s  = half_stb && toggle_en;
  assign lead_stb  = toggle_s && (sck == cpol_frame);
  assign trail_stb = toggle_s && (sck != cpol_frame);

  // half-period counter, wraps at div and is held at zero between frames
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (!run || half_stb) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

  // SCK register: toggles on strobes in XFER, otherwise parks at the idle polarity
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck <= cpol_idle;
    end else if (toggle_s) begin
      sck <= ~sck;
    end else if (toggle_en) begin
      sck <= sck;
    end else begin
      sck <= run ? cpol_frame : cpol_idle;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with per-frame mode/bit-order/divider and NUM_CS decoded chip selects.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NUM_CS = 4,
  parameter  int DIV_W  = 8,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int              BC_W     = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  spi_state_e        state_r, state_next_s;
  logic [DATA_W-1:0] tx_sr_r, rx_sr_r;
  logic [CS_W-1:0]   cs_idx_r, cs_sel_eff_s;
  logic              cpol_r, cpha_r, lsb_r;
  logic [DIV_W-1:0]  div_r;
  logic [BC_W-1:0]   bit_cnt_r;

  logic              run_s, xfer_s, half_stb_s, lead_stb_s, trail_stb_s;
  logic              start_acc_s, last_trail_s, sample_s, advance_s;
  logic [NUM_CS-1:0] cs_n_next_s;
  logic              mosi_next_s, busy_next_s, done_next_s;
  logic [DATA_W-1:0] rx_data_next_s;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  assign run_s        = (state_r != ST_IDLE);
  assign xfer_s       = (state_r == ST_XFER);
  assign start_acc_s  = (state_r == ST_IDLE) && start;
  assign last_trail_s = trail_stb_s && (bit_cnt_r == LAST_BIT);
  // cpha=0 samples on leading edges and shifts on trailing ones; cpha=1 the reverse
  assign sample_s     = cpha_r ? trail_stb_s : lead_stb_s;
  assign advance_s    = cpha_r ? lead_stb_s : (trail_stb_s && !last_trail_s);

  spi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run_s),
    .toggle_en (xfer_s),
    .div       (div_r),
    .cpol_idle (cpol),
    .cpol_frame(cpol_r),
    .half_stb  (half_stb_s),
    .lead_stb  (lead_stb_s),
    .trail_stb (trail_stb_s),
    .sck       (sck)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = start ? ST_LEAD : ST_IDLE;
      ST_LEAD:  state_next_s = half_stb_s ? ST_XFER : ST_LEAD;
      ST_XFER:  state_next_s = last_trail_s ? ST_TRAIL : ST_XFER;
      ST_TRAIL: state_next_s = half_stb_s ? ST_IDLE : ST_TRAIL;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // next values for the registered outputs
  always_comb begin
    cs_sel_eff_s = (state_r == ST_IDLE) ? cs_sel : cs_idx_r;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_n_next_s[i] = !((state_next_s != ST_IDLE) && (cs_sel_eff_s == CS_W'(i)));
    end
    busy_next_s    = (state_next_s != ST_IDLE);
    done_next_s    = (state_r == ST_TRAIL) && half_stb_s;
    rx_data_next_s = done_next_s ? rx_sr_r : rx_data;
    mosi_next_s    = 1'b0;
    case (state_r)
      ST_IDLE:  mosi_next_s = (start && !cpha) ? first_bit(tx_data, lsb_first) : 1'b0;
      ST_LEAD:  mosi_next_s = mosi;
      ST_XFER:  mosi_next_s = advance_s ? first_bit(tx_sr_r, lsb_r) : mosi;
      ST_TRAIL: mosi_next_s = half_stb_s ? 1'b0 : mosi;
      default:  mosi_next_s = 1'b0;
    endcase
  end

  // output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_n    <= {NUM_CS{1'b1}};
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= {DATA_W{1'b0}};
    end else begin
      cs_n    <= cs_n_next_s;
      mosi    <= mosi_next_s;
      busy    <= busy_next_s;
      done    <= done_next_s;
      rx_data <= rx_data_next_s;
    end
  end

  // frame settings captured at start, plus shift registers and bit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_sr_r   <= {DATA_W{1'b0}};
      rx_sr_r   <= {DATA_W{1'b0}};
      cs_idx_r  <= {CS_W{1'b0}};
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      lsb_r     <= 1'b0;
      div_r     <= {DIV_W{1'b0}};
      bit_cnt_r <= {BC_W{1'b0}};
    end else if (start_acc_s) begin
      // with cpha=0 the first bit goes straight to mosi, so the register starts pre-shifted
      tx_sr_r   <= cpha ? tx_data : shift_tx(tx_data, lsb_first);
      rx_sr_r   <= {DATA_W{1'b0}};
      cs_idx_r  <= cs_sel;
      cpol_r    <= cpol;
      cpha_r    <= cpha;
      lsb_r     <= lsb_first;
      div_r     <= clk_div;
      bit_cnt_r <= {BC_W{1'b0}};
    end else begin
      tx_sr_r   <= advance_s ? shift_tx(tx_sr_r, lsb_r) : tx_sr_r;
      rx_sr_r   <= sample_s ? shift_rx(rx_sr_r, miso, lsb_r) : rx_sr_r;
      bit_cnt_r <= trail_stb_s ? bit_cnt_r + BC_W'(1) : bit_cnt_r;
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: a queue holds expected completions, a monitor checks them.
module tb_spi_master_multi;
  import spi_pkg::*;

  logic        clk, rst, start, cpol, cpha, lsb_first, miso;
  logic [15:0] tx_data;
  logic [1:0]  cs_sel;
  logic [7:0]  clk_div;
  logic        sck, mosi, busy, done;
  logic [3:0]  cs_n;
  logic [15:0] rx_data;

  logic        start3;
  logic [1:0]  cs_sel3;
  logic        sck3, mosi3, busy3, done3;
  logic [2:0]  cs_n3;
  logic [15:0] rx_data3;

  spi_master_multi #(.DATA_W(16), .NUM_CS(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div), .miso(miso),
    .sck(sck), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done), .rx_data(rx_data)
  );

  spi_master_multi #(.DATA_W(16), .NUM_CS(3), .DIV_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .tx_data(tx_data), .cs_sel(cs_sel3),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div), .miso(miso),
    .sck(sck3), .mosi(mosi3), .cs_n(cs_n3), .busy(busy3), .done(done3), .rx_data(rx_data3)
  );

  typedef struct {
    logic [15:0] rx;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0, cyc = 0, tog = 0;
  logic        loop;
  logic [15:0] sl_tx, sl_rx;
  logic        sl_out, sl_first, sck_q, sel_q, cs3_low, busy3_seen;
  int          sl_idx, sl_rcv;
  wire         any_sel = ~&cs_n;

  assign miso = loop ? mosi : sl_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic bitof(input int i);
    if (i < 0 || i > 15) return 1'b0;
    return lsb_first ? sl_tx[i] : sl_tx[15-i];
  endfunction

  // scoreboard monitor: every done pulse pops one expectation
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data", {16'd0, rx_data}, {16'd0, e.rx});
        chk("done_cycle", cyc, e.c);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // slave model driven half a clk after SCK moves; also counts SCK edges inside a frame
  initial forever begin
    @(negedge clk);
    if (any_sel && !sel_q) begin
      sl_idx = 0; sl_rcv = 0; sl_rx = 16'd0;
      sl_out = cpha ? 1'b0 : bitof(0);
    end else if (any_sel && sck != sck_q) begin
      if (busy) tog++;
      if ((sck != cpol) == cpha) begin
        sl_out = cpha ? bitof(sl_idx) : bitof(sl_idx + 1);
        sl_idx++;
      end else begin
        if (sl_rcv == 0) sl_first = mosi;
        if (sl_rcv < 16) sl_rx[lsb_first ? sl_rcv : 15 - sl_rcv] = mosi;
        sl_rcv++;
      end
    end
    sck_q = sck;
    sel_q = any_sel;
    if (cs_n3 != 3'b111) cs3_low = 1'b1;
    if (busy3) busy3_seen = 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input logic lsb, input logic [7:0] div,
                             input logic [15:0] tx, input logic [1:0] sel,
                             input logic want, input logic [15:0] exp_rx, input int lat);
    {cpol, cpha} = m;
    lsb_first = lsb;
    clk_div = div;
    tx_data = tx;
    cs_sel = sel;
    start = 1'b1;
    if (want) sb.push_back('{exp_rx, cyc + 1 + lat});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  initial begin
    int t0, t1, d1, s3;
    bit got3;
    rst = 1'b0; start = 1'b0; start3 = 1'b0; cs_sel3 = 2'd0; loop = 1'b1;
    {cpol, cpha} = MODE2; lsb_first = 1'b0; clk_div = 8'd0; tx_data = 16'd0; cs_sel = 2'd0;
    sl_tx = 16'd0; sl_rx = 16'd0; sl_out = 1'b0; sl_first = 1'b0; sck_q = 1'b0; sel_q = 1'b0;
    sl_idx = 0; sl_rcv = 0; cs3_low = 1'b0; busy3_seen = 1'b0;
    cycles(3);
    chk("rst_cs_n", {28'd0, cs_n}, 32'hF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_rx", {16'd0, rx_data}, 32'd0);
    chk("rst_sck_cpol", {31'd0, sck}, 32'd1);
    rst = 1'b1;
    {cpol, cpha} = MODE0;
    cycles(2);

    // mode 0 loopback, H=2: done after 68 edges
    start_frame(MODE0, 1'b0, 8'd1, 16'h0407, 2'd0, 1'b1, 16'h0407, 68);
    cycles(2);
    chk("m0_cs_n", {28'd0, cs_n}, 32'hE);
    chk("m0_busy", {31'd0, busy}, 32'd1);
    wait_done(100, "m0_done_timeout");
    chk("m0_mosi_idle", {31'd0, mosi}, 32'd0);

    // mode 3, LSB first, slave returns A5C3
    loop = 1'b0; sl_tx = 16'hA5C3;
    {cpol, cpha} = MODE3;
    cycles(2);
    chk("m3_sck_idle", {31'd0, sck}, 32'd1);
    start_frame(MODE3, 1'b1, 8'd1, 16'h3C5B, 2'd3, 1'b1, 16'hA5C3, 68);
    cycles(4);
    chk("m3_cs_n", {28'd0, cs_n}, 32'h7);
    wait_done(100, "m3_done_timeout");
    chk("m3_slave_rx", {16'd0, sl_rx}, 32'h3C5B);
    chk("m3_first_bit", {31'd0, sl_first}, 32'd1);
    chk("m3_sck_after", {31'd0, sck}, 32'd1);

    // modes 1 then 2, clk_div=0, second start in the done cycle
    loop = 1'b1;
    cycles(2);
    t0 = tog;
    start_frame(MODE1, 1'b0, 8'd0, 16'hFFFF, 2'd1, 1'b1, 16'hFFFF, 34);
    wait_done(60, "b2b_a_timeout");
    t1 = tog; d1 = cyc;
    start_frame(MODE2, 1'b0, 8'd0, 16'h0000, 2'd1, 1'b1, 16'h0000, 34);
    wait_done(60, "b2b_b_timeout");
    chk("b2b_gap", cyc - d1, 32'd35);
    chk("b2b_sck_edges_a", t1 - t0, 32'd32);
    chk("b2b_sck_edges_b", tog - t1, 32'd32);

    // start during a frame is ignored and later input changes do not leak in
    cycles(2);
    start_frame(MODE0, 1'b0, 8'd2, 16'h1234, 2'd2, 1'b1, 16'h1234, 102);
    cycles(20);
    chk("mid_cs_n", {28'd0, cs_n}, 32'hB);
    start = 1'b1; tx_data = 16'hBEEF; cs_sel = 2'd1;
    cycles(1);
    start = 1'b0;
    chk("mid_cs_n_hold", {28'd0, cs_n}, 32'hB);
    wait_done(150, "mid_done_timeout");
    chk("mid_cs_release", {28'd0, cs_n}, 32'hF);
    cycles(120);

    // reset in the middle of XFER
    start_frame(MODE2, 1'b0, 8'd1, 16'hAAAA, 2'd1, 1'b0, 16'h0000, 68);
    cycles(30);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    cycles(1);
    chk("abort_cs_n", {28'd0, cs_n}, 32'hF);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rx", {16'd0, rx_data}, 32'd0);
    chk("abort_sck", {31'd0, sck}, 32'd1);
    chk("abort_mosi", {31'd0, mosi}, 32'd0);
    rst = 1'b1;
    cycles(100);

    // three chip selects, out-of-range index: no line asserted, frame still completes
    {cpol, cpha} = MODE0; clk_div = 8'd0;
    cycles(2);
    cs3_low = 1'b0; busy3_seen = 1'b0;
    cs_sel3 = 2'd3; start3 = 1'b1;
    s3 = cyc + 1;
    cycles(1);
    start3 = 1'b0;
    got3 = 1'b0;
    for (int i = 0; i < 60 && !got3; i++) begin
      @(posedge clk);
      #1;
      if (done3) got3 = 1'b1;
    end
    chk("cs3_done_seen", {31'd0, got3}, 32'd1);
    chk("cs3_done_cycle", cyc, s3 + 34);
    chk("cs3_never_low", {31'd0, cs3_low}, 32'd0);
    chk("cs3_was_busy", {31'd0, busy3_seen}, 32'd1);
    chk("cs3_rx", {16'd0, rx_data3}, 32'd0);
    chk("cs3_idle_lines", {30'd0, sck3, mosi3}, 32'd0);

    cycles(5);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
